// File: rtl/keypad_decoder_if.sv
// Keypad decoder bundle: scanner column index and raw rows in, debounced key report out.
// Optional key_ascii member is present only when KEYPAD_ASCII_EN is defined.
// master = the scanner/consumer side, slave = the decoder.
interface keypad_decoder_if;
  logic [1:0] count;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       multi_key;
`ifdef KEYPAD_ASCII_EN
  logic [7:0] key_ascii;
`endif

  modport master (
    output count, row,
    input  key_code, key_valid, key_held,
`ifdef KEYPAD_ASCII_EN
    input  key_ascii,
`endif
    input  multi_key
  );

  modport slave (
    input  count, row,
    output key_code, key_valid, key_held,
`ifdef KEYPAD_ASCII_EN
    output key_ascii,
`endif
    output multi_key
  );
endinterface

// File: rtl/keypad_decoder.sv
// 4x4 keypad decoder: syncs rows, builds 4-cycle scan frames, debounces, strobes one key code per press.
// Latency: key_valid is registered 1 clk after the frame end that completes the debounce (rows see 2 sync flops).
// No backpressure: key_valid is a single-cycle strobe; optional key_ascii output under KEYPAD_ASCII_EN.
module keypad_decoder #(
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int RELEASE_FRAMES  = 2
) (
  input  logic clk,
  input  logic reset,
  keypad_decoder_if.slave kp
);

  localparam logic [7:0] DF = 8'(DEBOUNCE_FRAMES);
  localparam logic [7:0] RF = 8'(RELEASE_FRAMES);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED} state_t;

  logic [3:0] row_s1, row_s2;
  logic [1:0] cnt_d1, cnt_d2;
  logic [1:0] acc_hits;
  logic [3:0] acc_code;

  state_t     state, state_nxt;
  logic [7:0] stab, stab_nxt;
  logic [7:0] rel, rel_nxt;
  logic [3:0] cand, cand_nxt;
  logic       accept;

  logic [2:0] zeros;
  logic [2:0] sum;
  logic [1:0] hits_tot;
  logic [1:0] row_idx;
  logic       hit_now;
  logic [3:0] code_tot;
  logic       frame_end;
  logic       f_none, f_single;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

`ifdef KEYPAD_ASCII_EN
  function automatic logic [7:0] to_ascii(input logic [3:0] code);
    logic [7:0] a;
    case (code)
      4'h0: a = 8'h31; 4'h1: a = 8'h32; 4'h2: a = 8'h33; 4'h3: a = 8'h41;
      4'h4: a = 8'h34; 4'h5: a = 8'h35; 4'h6: a = 8'h36; 4'h7: a = 8'h42;
      4'h8: a = 8'h37; 4'h9: a = 8'h38; 4'hA: a = 8'h39; 4'hB: a = 8'h43;
      4'hC: a = 8'h2A; 4'hD: a = 8'h30; 4'hE: a = 8'h23; default: a = 8'h44;
    endcase
    return a;
  endfunction
`endif

  // Two-flop row synchroniser with the column index delayed in lockstep.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_s1 <= 4'h0;
      row_s2 <= 4'h0;
      cnt_d1 <= 2'd0;
      cnt_d2 <= 2'd0;
    end else begin
      row_s1 <= kp.row;
      row_s2 <= row_s1;
      cnt_d1 <= kp.count;
      cnt_d2 <= cnt_d1;
    end
  end

  // Classify this cycle's rows and fold them into the running frame totals.
  always_comb begin
    zeros = {2'b00, ~row_s2[0]} + {2'b00, ~row_s2[1]} + {2'b00, ~row_s2[2]} + {2'b00, ~row_s2[3]};
    hit_now = (row_s2 != 4'hF);
    row_idx = 2'd0;
    if (!row_s2[0])      row_idx = 2'd0;
    else if (!row_s2[1]) row_idx = 2'd1;
    else if (!row_s2[2]) row_idx = 2'd2;
    else if (!row_s2[3]) row_idx = 2'd3;
    sum       = {1'b0, acc_hits} + zeros;
    hits_tot  = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    code_tot  = hit_now ? {row_idx, cnt_d2} : acc_code;
    frame_end = (cnt_d2 == 2'd3);
    f_none    = frame_end && (hits_tot == 2'd0);
    f_single  = frame_end && (hits_tot == 2'd1);
  end

  // Frame accumulator: clears on the frame-end cycle, which itself was already counted above.
  always_ff @(posedge clk) begin
    if (reset || frame_end) begin
      acc_hits <= 2'd0;
      acc_code <= 4'h0;
    end else begin
      acc_hits <= hits_tot;
      acc_code <= code_tot;
    end
  end

  // Debounce/release decisions, taken only at frame ends.
  always_comb begin
    state_nxt = state;
    stab_nxt  = stab;
    rel_nxt   = rel;
    cand_nxt  = cand;
    accept    = 1'b0;
    if (frame_end) begin
      case (state)
        IDLE: begin
          if (f_single) begin
            cand_nxt = code_tot;
            stab_nxt = 8'd1;
            if (DF <= 8'd1) begin
              state_nxt = PRESSED;
              rel_nxt   = 8'd0;
              accept    = 1'b1;
            end else begin
              state_nxt = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (f_single) begin
            if (code_tot == cand) begin
              stab_nxt = sat_inc(stab);
              if (stab_nxt >= DF) begin
                state_nxt = PRESSED;
                rel_nxt   = 8'd0;
                accept    = 1'b1;
              end
            end else begin
              cand_nxt = code_tot;
              stab_nxt = 8'd1;
            end
          end else begin
            state_nxt = IDLE;
            stab_nxt  = 8'd0;
          end
        end
        PRESSED: begin
          if (f_none) begin
            rel_nxt = sat_inc(rel);
            if (rel_nxt >= RF) begin
              state_nxt = IDLE;
              rel_nxt   = 8'd0;
              stab_nxt  = 8'd0;
            end
          end else begin
            rel_nxt = 8'd0;
          end
        end
        default: begin
          state_nxt = IDLE;
          stab_nxt  = 8'd0;
          rel_nxt   = 8'd0;
        end
      endcase
    end
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      stab         <= 8'd0;
      rel          <= 8'd0;
      cand         <= 4'h0;
      kp.key_code  <= 4'h0;
      kp.key_valid <= 1'b0;
      kp.key_held  <= 1'b0;
      kp.multi_key <= 1'b0;
`ifdef KEYPAD_ASCII_EN
      kp.key_ascii <= 8'h00;
`endif
    end else begin
      state        <= state_nxt;
      stab         <= stab_nxt;
      rel          <= rel_nxt;
      cand         <= cand_nxt;
      kp.key_valid <= accept;
      kp.key_held  <= (state_nxt == PRESSED);
      if (accept) begin
        kp.key_code <= cand_nxt;
`ifdef KEYPAD_ASCII_EN
        kp.key_ascii <= to_ascii(cand_nxt);
`endif
      end
      if (frame_end) kp.multi_key <= (hits_tot == 2'd2);
    end
  end

endmodule

// File: tb/tb_keypad_decoder.sv
// Randomised + directed bench for keypad_decoder with a frame-level reference model and strobe scoreboard.
// Model consumes the same row/count stream, predicts held/multi/code state per cycle and queues strobes.
// Monitor samples 1 ns after each rising edge and compares against the model.
module tb_keypad_decoder;

  localparam int DF = 4;
  localparam int RF = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  keypad_decoder_if kif();

  keypad_decoder #(.DEBOUNCE_FRAMES(DF), .RELEASE_FRAMES(RF)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kif)
  );

  typedef struct {
    int         cyc;
    logic [3:0] code;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // ---------------- reference model (frame-level) ----------------
  logic [3:0] p_row[2];
  logic [1:0] p_cnt[2];
  int         f_hits;
  logic [3:0] f_code;
  int         run_len, none_run;
  logic [3:0] run_code;
  logic       m_held, m_multi;
  logic [3:0] m_code;

  function automatic logic [7:0] lut(input logic [3:0] code);
    string keys;
    keys = "123A456B789C*0#D";
    return keys.getc(int'(code));
  endfunction

  always @(posedge clk) begin
    logic [3:0] r2;
    logic [1:0] c2;
    logic [1:0] lo;
    int         z;
    cyc++;
    if (reset) begin
      p_row[0] = 4'h0; p_row[1] = 4'h0;
      p_cnt[0] = 2'd0; p_cnt[1] = 2'd0;
      f_hits = 0; f_code = 4'h0;
      run_len = 0; none_run = 0; run_code = 4'h0;
      m_held = 1'b0; m_multi = 1'b0; m_code = 4'h0;
    end else begin
      r2 = p_row[1];
      c2 = p_cnt[1];
      z  = 0;
      lo = 2'd0;
      for (int i = 3; i >= 0; i--) begin
        if (!r2[i]) begin
          z++;
          lo = 2'(i);
        end
      end
      if (z > 0) begin
        f_hits = (f_hits + z > 2) ? 2 : f_hits + z;
        f_code = {lo, c2};
      end
      if (c2 == 2'd3) begin
        m_multi = (f_hits >= 2);
        if (!m_held) begin
          if (f_hits == 1) begin
            if (run_len > 0 && f_code == run_code) run_len++;
            else begin
              run_len  = 1;
              run_code = f_code;
            end
            if (run_len == DF) begin
              m_held   = 1'b1;
              m_code   = run_code;
              none_run = 0;
              run_len  = 0;
              q.push_back('{cyc, run_code});
            end
          end else begin
            run_len = 0;
          end
        end else begin
          if (f_hits == 0) begin
            none_run++;
            if (none_run == RF) begin
              m_held   = 1'b0;
              none_run = 0;
            end
          end else begin
            none_run = 0;
          end
        end
        f_hits = 0;
      end
      p_row[1] = p_row[0]; p_row[0] = kif.row;
      p_cnt[1] = p_cnt[0]; p_cnt[0] = kif.count;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, want);
    end
  endtask

  logic prev_kv = 1'b0;

  always @(posedge clk) begin
    logic exp_v;
    exp_t e;
    #1;
    while (q.size() > 0 && q[0].cyc < cyc) void'(q.pop_front());
    exp_v = (q.size() > 0 && q[0].cyc == cyc);
    chk("key_valid", 32'(kif.key_valid), 32'(exp_v));
    if (exp_v) begin
      e = q.pop_front();
      chk("strobe_code", 32'(kif.key_code), 32'(e.code));
`ifdef KEYPAD_ASCII_EN
      chk("strobe_ascii", 32'(kif.key_ascii), 32'(lut(e.code)));
`endif
    end
    chk("key_code", 32'(kif.key_code), 32'(m_code));
    chk("key_held", 32'(kif.key_held), 32'(m_held));
    chk("multi_key", 32'(kif.multi_key), 32'(m_multi));
`ifdef KEYPAD_ASCII_EN
    chk("key_ascii", 32'(kif.key_ascii), (m_held || m_code != 4'h0 || kif.key_ascii != 8'h00) ? 32'(lut(m_code)) : 32'h0);
`endif
    if (kif.key_valid === 1'b1) chk("valid_spacing", 32'(prev_kv), 32'h0);
    prev_kv = kif.key_valid;
  end

  // ---------------- stimulus ----------------
  logic [1:0] scan_c = 2'd0;

  function automatic logic [15:0] key(input int r, input int c);
    logic [15:0] k;
    k = 16'h0;
    k[r*4+c] = 1'b1;
    return k;
  endfunction

  task automatic tick(input logic [15:0] keys, input logic rst_v, input logic [3:0] glitch);
    logic [3:0] r;
    @(negedge clk);
    for (int i = 0; i < 4; i++) r[i] = ~keys[i*4 + int'(scan_c)];
    kif.count = scan_c;
    kif.row   = r ^ glitch;
    reset     = rst_v;
    scan_c    = scan_c + 2'd1;
  endtask

  task automatic frames(input logic [15:0] keys, input int n, input bit noisy);
    logic [3:0] g;
    for (int i = 0; i < n * 4; i++) begin
      g = 4'h0;
      if (noisy && $urandom_range(0, 15) == 0) g = 4'(1 << $urandom_range(0, 3));
      tick(keys, 1'b0, g);
    end
  endtask

  task automatic align();
    while (scan_c != 2'd0) tick(16'h0, 1'b0, 4'h0);
  endtask

  initial begin
    logic [15:0] k;
    int          kind;
    kif.count = 2'd0;
    kif.row   = 4'hF;
    repeat (3) tick(16'h0, 1'b1, 4'h0);

    // reset mid-scan while a key is being debounced, then 100 idle cycles
    frames(key(1, 2), 2, 0);
    tick(key(1, 2), 1'b0, 4'h0);
    tick(key(1, 2), 1'b0, 4'h0);
    repeat (3) tick(key(1, 2), 1'b1, 4'h0);
    repeat (100) tick(16'h0, 1'b0, 4'h0);
    align();

    // clean press row1/col2, then release
    frames(key(1, 2), 6, 0);
    frames(16'h0, 1, 0);
    frames(key(1, 2), 2, 0);
    frames(16'h0, 3, 0);

    // bounce: toggles every frame
    for (int i = 0; i < 10; i++) frames((i % 2 == 0) ? key(1, 2) : 16'h0, 1, 0);
    frames(16'h0, 2, 0);

    // ghost: rows 0 and 2 on column 1
    frames(key(0, 1) | key(2, 1), 4, 0);
    frames(16'h0, 2, 0);

    // row3/col1 press
    frames(key(3, 1), 6, 0);
    frames(16'h0, 3, 0);

    // key change mid-debounce, then reset mid-press
    frames(key(0, 0), 2, 0);
    frames(key(2, 3), 5, 0);
    tick(key(2, 3), 1'b1, 4'h0);
    tick(key(2, 3), 1'b1, 4'h0);
    frames(16'h0, 3, 0);

    // randomised phases
    for (int it = 0; it < 120; it++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 2) k = 16'h0;
      else if (kind <= 7) k = key($urandom_range(0, 3), $urandom_range(0, 3));
      else if (kind == 8) k = key($urandom_range(0, 3), $urandom_range(0, 3)) | key($urandom_range(0, 3), $urandom_range(0, 3));
      else begin
        k = 16'h0;
        repeat ($urandom_range(1, 3)) tick(16'h0, 1'b1, 4'h0);
      end
      frames(k, $urandom_range(1, 7), $urandom_range(0, 3) == 0);
    end

    frames(16'h0, 4, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("pending_strobes", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
